// File: rtl/cpu_pkg.sv
// Shared CPU definitions: control-bundle bit positions and register specifier width.
package cpu_pkg;

  localparam int CTRL_W     = 10;
  localparam int REG_ADDR_W = 5;

  // Bit positions inside the {regwrite..aluop} control bundle.
  localparam int CTRL_REGWRITE = 9;
  localparam int CTRL_MEMREAD  = 8;
  localparam int CTRL_MEMWRITE = 7;
  localparam int CTRL_MEMTOREG = 6;
  localparam int CTRL_BRANCH   = 5;
  localparam int CTRL_ALUSRC   = 4;
  localparam int CTRL_REGDST   = 3;
  localparam int ALUOP_MSB     = 2;
  localparam int ALUOP_LSB     = 0;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [CTRL_W-1:0]     ctrl_t;

endpackage

// File: rtl/id_ex_stage_reg_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  input  logic         clear_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != {W{1'b1}})) begin
      count_d = count_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use hazard detection, branch flush and
// saturating debug counters for stall and flush events.
module id_ex_stage_reg
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [REG_ADDR_W-1:0] IF_ID_rs,
  input  logic [REG_ADDR_W-1:0] IF_ID_rt,
  input  logic [REG_ADDR_W-1:0] IF_ID_rd,
  input  logic [CTRL_W-1:0]     ctrl_i,
  input  logic [DATA_W-1:0]     rs_data_i,
  input  logic [DATA_W-1:0]     rt_data_i,
  input  logic [DATA_W-1:0]     imm_i,
  input  logic [DATA_W-1:0]     pc4_i,
  input  logic                  flush_i,
  input  logic                  ext_stall_i,
  output logic [CTRL_W-1:0]     ID_EX_ctrl,
  output logic [DATA_W-1:0]     ID_EX_rs_data,
  output logic [DATA_W-1:0]     ID_EX_rt_data,
  output logic [DATA_W-1:0]     ID_EX_imm,
  output logic [DATA_W-1:0]     ID_EX_pc4,
  output logic [REG_ADDR_W-1:0] ID_EX_rs,
  output logic [REG_ADDR_W-1:0] ID_EX_rt,
  output logic [REG_ADDR_W-1:0] ID_EX_rd,
  output logic                  ID_EX_valid,
  output logic                  pc_write_o,
  output logic                  IF_ID_write_o,
  output logic [CNT_W-1:0]      stall_cnt_o,
  output logic [CNT_W-1:0]      flush_cnt_o
);

  ctrl_t             ctrl_q, ctrl_d;
  logic [DATA_W-1:0] rs_data_q, rs_data_d;
  logic [DATA_W-1:0] rt_data_q, rt_data_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [DATA_W-1:0] pc4_q, pc4_d;
  reg_addr_t         rs_q, rs_d;
  reg_addr_t         rt_q, rt_d;
  reg_addr_t         rd_q, rd_d;
  logic              valid_q, valid_d;

  logic hazard;
  logic stall_inc;

  // rt is compared even for instructions that never read it; a spurious stall is harmless.
  assign hazard = valid_q & ctrl_q[CTRL_MEMREAD] & (rt_q != '0) &
                  ((rt_q == IF_ID_rs) | (rt_q == IF_ID_rt));

  assign stall_inc = hazard & ~ext_stall_i & ~flush_i;

  always_comb begin
    ctrl_d    = ctrl_q;
    rs_data_d = rs_data_q;
    rt_data_d = rt_data_q;
    imm_d     = imm_q;
    pc4_d     = pc4_q;
    rs_d      = rs_q;
    rt_d      = rt_q;
    rd_d      = rd_q;
    valid_d   = valid_q;
    if (flush_i || (!ext_stall_i && hazard)) begin
      // Bubble: zero specifiers so it can never match the forwarding comparators.
      ctrl_d    = '0;
      rs_data_d = '0;
      rt_data_d = '0;
      imm_d     = '0;
      pc4_d     = '0;
      rs_d      = '0;
      rt_d      = '0;
      rd_d      = '0;
      valid_d   = 1'b0;
    end else if (!ext_stall_i) begin
      ctrl_d    = ctrl_i;
      rs_data_d = rs_data_i;
      rt_data_d = rt_data_i;
      imm_d     = imm_i;
      pc4_d     = pc4_i;
      rs_d      = IF_ID_rs;
      rt_d      = IF_ID_rt;
      rd_d      = IF_ID_rd;
      valid_d   = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ctrl_q    <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      pc4_q     <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
      valid_q   <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm_q     <= imm_d;
      pc4_q     <= pc4_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      rd_q      <= rd_d;
      valid_q   <= valid_d;
    end
  end

  // A taken branch must let the PC load its target even while a stall is pending.
  assign pc_write_o    = ~(ext_stall_i | hazard) | flush_i;
  assign IF_ID_write_o = ~(ext_stall_i | hazard) | flush_i;

  assign ID_EX_ctrl    = ctrl_q;
  assign ID_EX_rs_data = rs_data_q;
  assign ID_EX_rt_data = rt_data_q;
  assign ID_EX_imm     = imm_q;
  assign ID_EX_pc4     = pc4_q;
  assign ID_EX_rs      = rs_q;
  assign ID_EX_rt      = rt_q;
  assign ID_EX_rd      = rd_q;
  assign ID_EX_valid   = valid_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (stall_inc),
    .clear_i (1'b0),
    .count_o (stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (flush_i),
    .clear_i (1'b0),
    .count_o (flush_cnt_o)
  );

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Scoreboard bench for id_ex_stage_reg: expected register state is queued at each
// driven cycle and compared against the DUT one edge later.
module tb_id_ex_stage_reg;

  localparam int DW = 32;
  localparam int CW = 2;

  typedef struct packed {
    logic [9:0]    ctrl;
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic [DW-1:0] imm;
    logic [DW-1:0] pc4;
    logic [4:0]    rs;
    logic [4:0]    rt;
    logic [4:0]    rd;
    logic          valid;
    logic [CW-1:0] stall;
    logic [CW-1:0] flush;
  } obs_t;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic [4:0]    IF_ID_rs = '0, IF_ID_rt = '0, IF_ID_rd = '0;
  logic [9:0]    ctrl_i = '0;
  logic [DW-1:0] rs_data_i = '0, rt_data_i = '0, imm_i = '0, pc4_i = '0;
  logic          flush_i = 1'b0, ext_stall_i = 1'b0;

  logic [9:0]    ID_EX_ctrl;
  logic [DW-1:0] ID_EX_rs_data, ID_EX_rt_data, ID_EX_imm, ID_EX_pc4;
  logic [4:0]    ID_EX_rs, ID_EX_rt, ID_EX_rd;
  logic          ID_EX_valid, pc_write_o, IF_ID_write_o;
  logic [CW-1:0] stall_cnt_o, flush_cnt_o;

  id_ex_stage_reg #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .IF_ID_rs      (IF_ID_rs),
    .IF_ID_rt      (IF_ID_rt),
    .IF_ID_rd      (IF_ID_rd),
    .ctrl_i        (ctrl_i),
    .rs_data_i     (rs_data_i),
    .rt_data_i     (rt_data_i),
    .imm_i         (imm_i),
    .pc4_i         (pc4_i),
    .flush_i       (flush_i),
    .ext_stall_i   (ext_stall_i),
    .ID_EX_ctrl    (ID_EX_ctrl),
    .ID_EX_rs_data (ID_EX_rs_data),
    .ID_EX_rt_data (ID_EX_rt_data),
    .ID_EX_imm     (ID_EX_imm),
    .ID_EX_pc4     (ID_EX_pc4),
    .ID_EX_rs      (ID_EX_rs),
    .ID_EX_rt      (ID_EX_rt),
    .ID_EX_rd      (ID_EX_rd),
    .ID_EX_valid   (ID_EX_valid),
    .pc_write_o    (pc_write_o),
    .IF_ID_write_o (IF_ID_write_o),
    .stall_cnt_o   (stall_cnt_o),
    .flush_cnt_o   (flush_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  obs_t model = '0;
  obs_t sb_q[$];
  obs_t got, exp_v;
  int   errors = 0;
  int   checks = 0;

  function automatic obs_t observed();
    obs_t o;
    o.ctrl    = ID_EX_ctrl;
    o.rs_data = ID_EX_rs_data;
    o.rt_data = ID_EX_rt_data;
    o.imm     = ID_EX_imm;
    o.pc4     = ID_EX_pc4;
    o.rs      = ID_EX_rs;
    o.rt      = ID_EX_rt;
    o.rd      = ID_EX_rd;
    o.valid   = ID_EX_valid;
    o.stall   = stall_cnt_o;
    o.flush   = flush_cnt_o;
    return o;
  endfunction

  function automatic logic model_hazard();
    return model.valid & model.ctrl[8] & (model.rt != 5'd0) &
           ((model.rt == IF_ID_rs) | (model.rt == IF_ID_rt));
  endfunction

  function automatic obs_t bubble_of(obs_t m);
    obs_t b = '0;
    b.stall = m.stall;
    b.flush = m.flush;
    return b;
  endfunction

  task automatic set_in(input logic [9:0] c, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [DW-1:0] a, input logic [DW-1:0] b);
    ctrl_i    = c;
    IF_ID_rs  = rs;
    IF_ID_rt  = rt;
    IF_ID_rd  = rd;
    rs_data_i = a;
    rt_data_i = b;
    imm_i     = a ^ 32'h0000_ffff;
    pc4_i     = b + 32'd4;
  endtask

  // Predict the state after the coming edge, queue it, then advance past the edge.
  task automatic clock_edge();
    obs_t n = model;
    logic hz = model_hazard();
    if (flush_i) begin
      n = bubble_of(model);
      if (n.flush != {CW{1'b1}}) n.flush = n.flush + 1'b1;
    end else if (ext_stall_i) begin
      n = model;
    end else if (hz) begin
      n = bubble_of(model);
      if (n.stall != {CW{1'b1}}) n.stall = n.stall + 1'b1;
    end else begin
      n.ctrl = ctrl_i;  n.rs_data = rs_data_i; n.rt_data = rt_data_i;
      n.imm = imm_i;    n.pc4 = pc4_i;
      n.rs = IF_ID_rs;  n.rt = IF_ID_rt;       n.rd = IF_ID_rd;
      n.valid = 1'b1;
    end
    sb_q.push_back(n);
    model = n;
    @(posedge clk_i);
    #1;
    $display("edge t=%0t ctrl=%h rs=%0d rt=%0d rd=%0d valid=%0b stall=%0d flush=%0d",
             $time, ID_EX_ctrl, ID_EX_rs, ID_EX_rt, ID_EX_rd, ID_EX_valid, stall_cnt_o, flush_cnt_o);
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (observed() !== obs_t'(0)) begin
      errors++; $display("FAIL reset_state: got %h required 0", observed());
    end
    checks++;
    if ({pc_write_o, IF_ID_write_o} !== 2'b11) begin
      errors++; $display("FAIL reset_we: got %b required 11", {pc_write_o, IF_ID_write_o});
    end
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic test_capture();
    @(negedge clk_i);
    set_in(10'h200, 5'd3, 5'd4, 5'd5, 32'h11, 32'h22);
    clock_edge();
    got = observed(); exp_v = sb_q.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL capture: got %h required %h", got, exp_v); end
    checks++;
    if ({ID_EX_rd, ID_EX_rs_data, ID_EX_valid} !== {5'd5, 32'h11, 1'b1}) begin
      errors++; $display("FAIL capture_fields: rd=%0d data=%h valid=%b required 5 11 1",
                         ID_EX_rd, ID_EX_rs_data, ID_EX_valid);
    end
  endtask

  task automatic test_load_use();
    @(negedge clk_i);
    set_in(10'h340, 5'd2, 5'd8, 5'd0, 32'h100, 32'h200);  // lw rt=8
    clock_edge();
    got = observed(); exp_v = sb_q.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL load_capture: got %h required %h", got, exp_v); end
    @(negedge clk_i);
    set_in(10'h200, 5'd8, 5'd9, 5'd10, 32'h33, 32'h44);
    #1; checks++;
    if ({pc_write_o, IF_ID_write_o} !== 2'b00) begin
      errors++; $display("FAIL load_use_we: got %b required 00", {pc_write_o, IF_ID_write_o});
    end
    clock_edge();
    got = observed(); exp_v = sb_q.pop_front(); checks++;
    if (got !== exp_v || got.valid !== 1'b0 || got.stall !== 2'd1) begin
      errors++; $display("FAIL load_use_bubble: got %h required %h", got, exp_v);
    end
    checks++;
    if ({pc_write_o, IF_ID_write_o} !== 2'b11) begin
      errors++; $display("FAIL load_use_release: got %b required 11", {pc_write_o, IF_ID_write_o});
    end
    clock_edge();
    got = observed(); exp_v = sb_q.pop_front(); checks++;
    if (got !== exp_v || got.rd !== 5'd10) begin
      errors++; $display("FAIL load_use_recapture: got %h required %h", got, exp_v);
    end
  endtask

  task automatic test_load_zero();
    logic [CW-1:0] stall_before;
    @(negedge clk_i);
    set_in(10'h340, 5'd1, 5'd0, 5'd0, 32'h5, 32'h6);
    clock_edge();
    got = observed(); exp_v = sb_q.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL load_zero_capture: got %h required %h", got, exp_v); end
    stall_before = stall_cnt_o;
    @(negedge clk_i);
    set_in(10'h200, 5'd0, 5'd0, 5'd7, 32'h7, 32'h8);
    #1; checks++;
    if (pc_write_o !== 1'b1) begin errors++; $display("FAIL load_zero_we: got %b required 1", pc_write_o); end
    clock_edge();
    got = observed(); exp_v = sb_q.pop_front(); checks++;
    if (got !== exp_v || got.valid !== 1'b1 || got.stall !== stall_before) begin
      errors++; $display("FAIL load_zero_nostall: got %h required %h", got, exp_v);
    end
  endtask

  task automatic test_flush_priority();
    logic [CW-1:0] stall_before;
    @(negedge clk_i);
    set_in(10'h340, 5'd2, 5'd8, 5'd0, 32'h1, 32'h2);
    clock_edge();
    void'(sb_q.pop_front());
    stall_before = stall_cnt_o;
    @(negedge clk_i);
    set_in(10'h200, 5'd8, 5'd8, 5'd3, 32'h9, 32'h9);
    flush_i = 1'b1; ext_stall_i = 1'b1;
    #1; checks++;
    if ({pc_write_o, IF_ID_write_o} !== 2'b11) begin
      errors++; $display("FAIL flush_we: got %b required 11", {pc_write_o, IF_ID_write_o});
    end
    clock_edge();
    flush_i = 1'b0; ext_stall_i = 1'b0;
    got = observed(); exp_v = sb_q.pop_front(); checks++;
    if (got !== exp_v || got.flush !== 2'd1 || got.stall !== stall_before || got.valid !== 1'b0) begin
      errors++; $display("FAIL flush_bubble: got %h required %h", got, exp_v);
    end
  endtask

  task automatic test_ext_stall();
    @(negedge clk_i);
    set_in(10'h2a5, 5'd11, 5'd12, 5'd13, 32'hdead, 32'hbeef);
    clock_edge();
    void'(sb_q.pop_front());
    @(negedge clk_i);
    set_in(10'h011, 5'd14, 5'd15, 5'd16, 32'h1234, 32'h5678);
    ext_stall_i = 1'b1;
    #1; checks++;
    if (pc_write_o !== 1'b0) begin errors++; $display("FAIL ext_stall_we: got %b required 0", pc_write_o); end
    clock_edge();
    ext_stall_i = 1'b0;
    got = observed(); exp_v = sb_q.pop_front(); checks++;
    if (got !== exp_v || got.rd !== 5'd13) begin
      errors++; $display("FAIL ext_stall_hold: got %h required %h", got, exp_v);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      set_in(10'h340, 5'd1, 5'd9, 5'd0, 32'h0, 32'h0);
      clock_edge();
      void'(sb_q.pop_front());
      @(negedge clk_i);
      set_in(10'h200, 5'd9, 5'd2, 5'd4, 32'h0, 32'h0);
      clock_edge();
      got = observed(); exp_v = sb_q.pop_front(); checks++;
      if (got !== exp_v) begin errors++; $display("FAIL sat_step%0d: got %h required %h", i, got, exp_v); end
    end
    checks++;
    if (stall_cnt_o !== 2'd3) begin errors++; $display("FAIL saturation: got %0d required 3", stall_cnt_o); end
  endtask

  task automatic test_back_to_back();
    logic exp_we;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk_i);
      set_in(10'($urandom), 5'($urandom_range(0, 6)), 5'($urandom_range(0, 6)),
             5'($urandom_range(0, 31)), $urandom, $urandom);
      flush_i     = ($urandom_range(0, 7) == 0);
      ext_stall_i = ($urandom_range(0, 5) == 0);
      #1;
      exp_we = ~(ext_stall_i | model_hazard()) | flush_i;
      checks++;
      if ({pc_write_o, IF_ID_write_o} !== {exp_we, exp_we}) begin
        errors++; $display("FAIL b2b_we%0d: got %b required %b", i, {pc_write_o, IF_ID_write_o}, {exp_we, exp_we});
      end
      clock_edge();
      got = observed(); exp_v = sb_q.pop_front(); checks++;
      if (got !== exp_v) begin errors++; $display("FAIL b2b_state%0d: got %h required %h", i, got, exp_v); end
    end
    flush_i = 1'b0; ext_stall_i = 1'b0;
  endtask

  task automatic test_reset_mid_stall();
    @(negedge clk_i);
    set_in(10'h340, 5'd1, 5'd8, 5'd0, 32'h1, 32'h1);
    clock_edge();
    void'(sb_q.pop_front());
    @(negedge clk_i);
    set_in(10'h200, 5'd8, 5'd3, 5'd6, 32'h77, 32'h88);
    #2;
    rst_i = 1'b1;
    #1;
    model = '0;
    sb_q.delete();
    checks++;
    if (observed() !== obs_t'(0) || pc_write_o !== 1'b1) begin
      errors++; $display("FAIL reset_mid: got %h we=%b required 0 we=1", observed(), pc_write_o);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    clock_edge();
    got = observed(); exp_v = sb_q.pop_front(); checks++;
    if (got !== exp_v || got.valid !== 1'b1 || got.rd !== 5'd6) begin
      errors++; $display("FAIL post_reset_capture: got %h required %h", got, exp_v);
    end
  endtask

  initial begin
    test_reset();
    test_capture();
    test_load_use();
    test_load_zero();
    test_flush_priority();
    test_ext_stall();
    test_saturation();
    test_back_to_back();
    test_reset_mid_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
ID/EX pipeline register for the 5-stage pipelined CPU, with integrated load-use hazard detection and branch flush.
- Captures decoded control, operands and register specifiers each cycle.
- Drives ID_EX_rs/ID_EX_rt/ID_EX_rd to the EX-stage forwarding logic.
- Generates PC/IF-ID write enables and inserts bubbles.
- Keeps saturating stall and flush event counters for debug.

Parameters:
DATA_W, 32, width of operand, immediate and PC fields
CNT_W, 16, width of the stall/flush event counters

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous, active-high reset
IF_ID_rs  in  5  rs specifier of decoding instruction
IF_ID_rt  in  5  rt specifier of decoding instruction
IF_ID_rd  in  5  rd specifier of decoding instruction
ctrl_i  in  10  decoded control {regwrite, memread, memwrite, memtoreg, branch, alusrc, regdst, aluop[2:0]}
rs_data_i  in  DATA_W  register file read data 1
rt_data_i  in  DATA_W  register file read data 2
imm_i  in  DATA_W  sign-extended immediate
pc4_i  in  DATA_W  PC+4 of decoding instruction
flush_i  in  1  branch taken, resolved downstream; kill ID/EX contents
ext_stall_i  in  1  global pipeline hold (memory wait)
ID_EX_ctrl  out  10  registered control, same packing as ctrl_i
ID_EX_rs_data  out  DATA_W  registered operand A
ID_EX_rt_data  out  DATA_W  registered operand B
ID_EX_imm  out  DATA_W  registered immediate
ID_EX_pc4  out  DATA_W  registered PC+4
ID_EX_rs  out  5  registered rs (to forwarding unit)
ID_EX_rt  out  5  registered rt (to forwarding unit)
ID_EX_rd  out  5  registered rd
ID_EX_valid  out  1  entry holds a real instruction
pc_write_o  out  1  PC update enable (combinational)
IF_ID_write_o  out  1  IF/ID register write enable (combinational)
stall_cnt_o  out  CNT_W  load-use stall cycles, saturating
flush_cnt_o  out  CNT_W  flush events, saturating

Behaviour:
- Reset (async, rst_i=1): every registered output = 0, ID_EX_valid=0, both counters 0. Effect is immediate, no clock needed. Deassertion is sampled on clk_i.
- Hazard, combinational:
  - hazard = ID_EX_valid & ID_EX_ctrl.memread & (ID_EX_rt != 0) & ((ID_EX_rt == IF_ID_rs) | (ID_EX_rt == IF_ID_rt)).
  - The rt comparison is always made, even when the decoding instruction does not read rt.
- Per-edge priority, highest first:
  1. flush_i=1: load bubble (all ctrl, specifiers, data = 0, valid=0). flush_cnt increments. hazard and ext_stall_i are ignored for this edge.
  2. ext_stall_i=1: all registers hold, including valid. Counters hold.
  3. hazard=1: load bubble. stall_cnt increments.
  4. Otherwise: capture all inputs, valid=1.
- Write enables:
  - pc_write_o = IF_ID_write_o = ~(ext_stall_i | hazard) | flush_i.
  - Flush overrides both stalls so the PC can take the branch target.
- Latency: 1 cycle from inputs to ID_EX_* outputs.
- A load-use stall lasts exactly 1 cycle. The inserted bubble has memread=0, so hazard drops on the next cycle.
- A bubble carries regwrite=0 and rd/rt=0, so it never matches forwarding comparisons.
- Counters saturate at all-ones and do not wrap.
- Reset mid-stall: registers clear at once; the first post-reset edge performs a normal capture.

Decomposition:
- Shared package (cpu_pkg): control-bundle bit positions (CTRL_REGWRITE=9 … ALUOP_LSB=0), CTRL_W=10, REG_ADDR_W=5.
- One sub-module, sat_counter (width parameter, inc and clear inputs), instantiated twice for the stall and flush counters.
- Hazard detection stays inline.

Test Plan:
- Reset: assert rst_i between clock edges -> all outputs 0 immediately; pc_write_o=1.
- Normal capture: ctrl_i=0x200 (regwrite), IF_ID_rs=3, IF_ID_rt=4, IF_ID_rd=5, rs_data_i=0x11 -> next edge ID_EX_rd=5, ID_EX_rs_data=0x11, valid=1.
- Load-use: lw with rt=8 in ID/EX, then IF_ID_rs=8 -> for one cycle pc_write_o=0 and IF_ID_write_o=0; next edge bubble (ctrl=0, valid=0); stall_cnt=1; following edge captures the instruction.
- Load to $0: ID/EX memread with rt=0, IF_ID_rs=0 -> no stall; stall_cnt stays 0.
- Flush with simultaneous hazard and ext_stall_i -> bubble loaded; pc_write_o=1; flush_cnt=1; stall_cnt unchanged.
- Saturation: with CNT_W=2, drive 5 load-use stalls -> stall_cnt_o=3.
